// File: rtl/sram_async_ctrl_if.sv
// Single-beat request/response channel between the bus bridge and the async SRAM controller.
// The bridge side uses the master modport, the controller the slave modport.
interface sram_async_ctrl_if #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 17
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [W_ADDR-1:0]     req_addr;
  logic [W_DATA-1:0]     req_wdata;
  logic [W_DATA/8-1:0]   req_wstrb;
  logic                  rsp_valid;
  logic [W_DATA-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_async_ctrl.sv
// Synchronous initiator for an external asynchronous SRAM: turns single-beat requests into
// timed read/write strobe sequences with every pad-facing output registered.
module sram_async_ctrl #(
  parameter int W_DATA       = 16,
  parameter int W_ADDR       = 17,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  sram_async_ctrl_if.slave    bus,
  output logic [W_ADDR-1:0]   sram_a,
  output logic [W_DATA-1:0]   sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [W_DATA-1:0]   sram_dq_in,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [W_DATA/8-1:0] sram_ben_n
);
  localparam int NB = W_DATA / 8;

  typedef enum logic [2:0] {IDLE, RD, RD_TURN, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              ce_n_nx, oe_n_nx, we_n_nx, dq_oe_nx;
  logic [W_ADDR-1:0] a_nx;
  logic [W_DATA-1:0] dq_out_nx;
  logic [NB-1:0]     ben_n_nx;
  logic              rsp_valid, rsp_valid_nx;
  logic [W_DATA-1:0] rsp_rdata, rsp_rdata_nx;
  logic              accept;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign accept        = bus.req_valid && bus.req_ready;

  // Next-state logic computes the value each pad register takes at the coming edge.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    ce_n_nx      = 1'b1;
    oe_n_nx      = 1'b1;
    we_n_nx      = 1'b1;
    dq_oe_nx     = 1'b0;
    a_nx         = sram_a;
    dq_out_nx    = sram_dq_out;
    ben_n_nx     = sram_ben_n;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    case (state)
      IDLE: begin
        if (accept) begin
          a_nx      = bus.req_addr;
          dq_out_nx = bus.req_wdata;
          ce_n_nx   = 1'b0;
          if (bus.req_write) begin
            ben_n_nx = ~bus.req_wstrb;
            dq_oe_nx = 1'b1;
            state_nx = WR_SETUP;
          end else begin
            ben_n_nx = '0;
            oe_n_nx  = 1'b0;
            cnt_nx   = 4'(READ_CYCLES - 1);
            state_nx = RD;
          end
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          rsp_rdata_nx = sram_dq_in;
          rsp_valid_nx = 1'b1;
          state_nx     = RD_TURN;
        end else begin
          ce_n_nx = 1'b0;
          oe_n_nx = 1'b0;
          cnt_nx  = cnt - 4'd1;
        end
      end
      RD_TURN: state_nx = IDLE;
      WR_SETUP: begin
        ce_n_nx  = 1'b0;
        dq_oe_nx = 1'b1;
        we_n_nx  = 1'b0;
        cnt_nx   = 4'(WRITE_CYCLES - 1);
        state_nx = WR_PULSE;
      end
      WR_PULSE: begin
        ce_n_nx  = 1'b0;
        dq_oe_nx = 1'b1;
        if (cnt == 4'd0) begin
          rsp_valid_nx = 1'b1;
          state_nx     = WR_HOLD;
        end else begin
          we_n_nx = 1'b0;
          cnt_nx  = cnt - 4'd1;
        end
      end
      // DQ drive drops on the edge leaving the hold cycle.
      WR_HOLD: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_a      <= '0;
      sram_dq_out <= '0;
      sram_ben_n  <= '1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sram_ce_n   <= ce_n_nx;
      sram_oe_n   <= oe_n_nx;
      sram_we_n   <= we_n_nx;
      sram_dq_oe  <= dq_oe_nx;
      sram_a      <= a_nx;
      sram_dq_out <= dq_out_nx;
      sram_ben_n  <= ben_n_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_rdata   <= rsp_rdata_nx;
    end
  end
endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: directed vector table, multi-cycle corner sequences and a
// short-timing instance exercised with a random operation mix against an SRAM model.
module tb_sram_async_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  sram_async_ctrl_if #(.W_DATA(16), .W_ADDR(17)) bus1();
  sram_async_ctrl_if #(.W_DATA(16), .W_ADDR(17)) bus2();

  logic [16:0] a1, a2;
  logic [15:0] dqo1, dqi1, dqo2, dqi2;
  logic        dqoe1, ce1, oe1, we1, dqoe2, ce2, oe2, we2;
  logic [1:0]  ben1, ben2;

  sram_async_ctrl #(.W_DATA(16), .W_ADDR(17), .READ_CYCLES(2), .WRITE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .sram_a(a1), .sram_dq_out(dqo1),
    .sram_dq_oe(dqoe1), .sram_dq_in(dqi1), .sram_ce_n(ce1), .sram_oe_n(oe1),
    .sram_we_n(we1), .sram_ben_n(ben1));

  sram_async_ctrl #(.W_DATA(16), .W_ADDR(17), .READ_CYCLES(1), .WRITE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .sram_a(a2), .sram_dq_out(dqo2),
    .sram_dq_oe(dqoe2), .sram_dq_in(dqi2), .sram_ce_n(ce2), .sram_oe_n(oe2),
    .sram_we_n(we2), .sram_ben_n(ben2));

  // Async SRAM models: combinational read when CE and OE are low, lane write while WE is low.
  logic [15:0] mem1 [0:(1<<17)-1];
  logic [15:0] mem2 [0:15];
  assign dqi1 = (!ce1 && !oe1) ? mem1[a1] : 16'h0000;
  assign dqi2 = (!ce2 && !oe2) ? mem2[a2[3:0]] : 16'h0000;
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!ce1 && !we1 && dqoe1 && !ben1[b]) mem1[a1][b*8 +: 8] = dqo1[b*8 +: 8];
      if (!ce2 && !we2 && dqoe2 && !ben2[b]) mem2[a2[3:0]][b*8 +: 8] = dqo2[b*8 +: 8];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int viol     = 0;
  logic rsp1_prev = 1'b0, rsp2_prev = 1'b0;

  always @(negedge clk) begin
    if (dqoe1 && !oe1) viol++;
    if (dqoe2 && !oe2) viol++;
    if (bus1.rsp_valid && (rsp1_prev || bus1.req_ready)) viol++;
    if (bus2.rsp_valid && (rsp2_prev || bus2.req_ready)) viol++;
    rsp1_prev = bus1.rsp_valid;
    rsp2_prev = bus2.rsp_valid;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] st);
    logic [15:0] r;
    r = old;
    for (int b = 0; b < 2; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  typedef struct {
    int          lat;
    int          n_dqoe;
    int          n_we;
    int          n_oe;
    int          a_bad;
    logic [1:0]  ben;
    logic        we_first;
    logic        we_last;
    logic [15:0] rd;
  } res_t;

  task automatic op1(input logic wr, input logic [16:0] addr, input logic [15:0] wd,
                     input logic [1:0] st, output res_t r);
    int guard;
    r = '{0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 16'h0};
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = wr; bus1.req_addr = addr;
    bus1.req_wdata = wd;   bus1.req_wstrb = st;
    guard = 0;
    while (!bus1.req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    do begin
      @(negedge clk);
      r.lat++;
      if (dqoe1) r.n_dqoe++;
      if (!we1) r.n_we++;
      if (!oe1) r.n_oe++;
      if (a1 !== addr) r.a_bad++;
      if (r.lat == 1) begin r.ben = ben1; r.we_first = we1; end
    end while (!bus1.rsp_valid && r.lat < 40);
    r.we_last = we1;
    r.rd = bus1.rsp_rdata;
  endtask

  task automatic op2(input logic wr, input logic [16:0] addr, input logic [15:0] wd,
                     input logic [1:0] st, output int lat, output logic [15:0] rd);
    int guard;
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_write = wr; bus2.req_addr = addr;
    bus2.req_wdata = wd;   bus2.req_wstrb = st;
    guard = 0;
    while (!bus2.req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus2.rsp_valid && lat < 40);
    rd = bus2.rsp_rdata;
  endtask

  typedef struct {
    logic        wr;
    logic [16:0] addr;
    logic [15:0] wd;
    logic [1:0]  st;
    logic [15:0] exp_rd;
    logic [1:0]  exp_ben;
    int          exp_lat;
  } vec_t;

  vec_t        tbl [8];
  res_t        r;
  logic [15:0] ref2 [0:15];
  logic [15:0] bb_exp [$];
  logic        bb_isrd [$];

  initial begin
    int          k, nrsp, cyc, acc_prev, lat, nr;
    logic        prev_wr, wr, isrd;
    logic [16:0] addr;
    logic [15:0] wd, e, rd;
    logic [1:0]  st;

    tbl[0] = '{1'b1, 17'h12345, 16'hBEEF, 2'b11, 16'h0000, 2'b00, 4};
    tbl[1] = '{1'b0, 17'h12345, 16'h0000, 2'b00, 16'hBEEF, 2'b00, 3};
    tbl[2] = '{1'b1, 17'h00000, 16'h00AA, 2'b01, 16'h0000, 2'b10, 4};
    tbl[3] = '{1'b0, 17'h00000, 16'h0000, 2'b11, 16'h12AA, 2'b00, 3};
    tbl[4] = '{1'b1, 17'h00005, 16'hFFFF, 2'b00, 16'h0000, 2'b11, 4};
    tbl[5] = '{1'b0, 17'h00005, 16'h0000, 2'b00, 16'h5555, 2'b00, 3};
    tbl[6] = '{1'b1, 17'h1FFFF, 16'hA5C3, 2'b10, 16'h0000, 2'b01, 4};
    tbl[7] = '{1'b0, 17'h1FFFF, 16'h0000, 2'b00, 16'hA50F, 2'b00, 3};

    rst = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_wstrb = '0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
    bus2.req_wdata = '0;   bus2.req_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ce_n", 32'(ce1), 32'd1);
    chk("rst_oe_n", 32'(oe1), 32'd1);
    chk("rst_we_n", 32'(we1), 32'd1);
    chk("rst_dq_oe", 32'(dqoe1), 32'd0);
    chk("rst_ben_n", 32'(ben1), 32'h3);
    chk("rst_addr", 32'(a1), 32'd0);
    chk("rst_dq_out", 32'(dqo1), 32'd0);
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus1.rsp_rdata), 32'd0);
    chk("rst_ready_low", 32'(bus1.req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus1.req_ready), 32'd1);

    op1(1'b1, 17'h00000, 16'h1234, 2'b11, r);
    op1(1'b1, 17'h00005, 16'h5555, 2'b11, r);
    op1(1'b1, 17'h1FFFF, 16'h0F0F, 2'b11, r);

    for (int i = 0; i < 8; i++) begin
      op1(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].st, r);
      chk($sformatf("v%0d_latency", i), 32'(r.lat), 32'(tbl[i].exp_lat));
      chk($sformatf("v%0d_ben_n", i), 32'(r.ben), 32'(tbl[i].exp_ben));
      chk($sformatf("v%0d_addr_stable", i), 32'(r.a_bad), 32'd0);
      chk($sformatf("v%0d_dq_oe_cycles", i), 32'(r.n_dqoe), tbl[i].wr ? 32'd4 : 32'd0);
      chk($sformatf("v%0d_we_low_cycles", i), 32'(r.n_we), tbl[i].wr ? 32'd2 : 32'd0);
      chk($sformatf("v%0d_oe_low_cycles", i), 32'(r.n_oe), tbl[i].wr ? 32'd0 : 32'd2);
      if (tbl[i].wr) begin
        chk($sformatf("v%0d_we_setup", i), 32'(r.we_first), 32'd1);
        chk($sformatf("v%0d_we_hold", i), 32'(r.we_last), 32'd1);
      end else begin
        chk($sformatf("v%0d_rdata", i), 32'(r.rd), 32'(tbl[i].exp_rd));
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready_back", i), 32'(bus1.req_ready), 32'd1);
      chk($sformatf("v%0d_idle_dq_oe", i), 32'(dqoe1), 32'd0);
      chk($sformatf("v%0d_idle_rsp", i), 32'(bus1.rsp_valid), 32'd0);
      chk($sformatf("v%0d_idle_ce_n", i), 32'(ce1), 32'd1);
    end

    // rsp_rdata keeps the last read value across a write
    op1(1'b1, 17'h00007, 16'h7777, 2'b11, r);
    chk("rdata_hold", 32'(r.rd), 32'h0000A50F);
    chk("addr_held_idle", 32'(a1), 32'h00007);

    // back-to-back alternating write/read with req_valid held high
    k = 0; nrsp = 0; cyc = 0; acc_prev = 0; prev_wr = 1'b0;
    @(negedge clk);
    while ((k < 8 || nrsp < 8) && cyc < 300) begin
      if (bus1.rsp_valid) begin
        nrsp++;
        if (bb_isrd.size() > 0) begin
          isrd = bb_isrd.pop_front();
          e = bb_exp.pop_front();
          if (isrd) chk($sformatf("bb_rdata%0d", nrsp), 32'(bus1.rsp_rdata), 32'(e));
        end
      end
      if (bus1.req_ready) begin
        if (k < 8) begin
          if (k > 0) chk($sformatf("bb_gap%0d", k), 32'(cyc - acc_prev), prev_wr ? 32'd5 : 32'd4);
          wr = (k % 2 == 0);
          bus1.req_valid = 1'b1;
          bus1.req_write = wr;
          bus1.req_addr  = 17'(17'h100 + k / 2);
          bus1.req_wdata = 16'hC0DE ^ 16'(k);
          bus1.req_wstrb = 2'b11;
          bb_isrd.push_back(!wr);
          bb_exp.push_back(16'hC0DE ^ 16'(k - 1));
          acc_prev = cyc; prev_wr = wr; k++;
        end else begin
          bus1.req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus1.req_valid = 1'b0;
    chk("bb_rsp_count", 32'(nrsp), 32'd8);

    // reset during the first WE pulse cycle aborts the write
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 17'h00200;
    bus1.req_wdata = 16'h9999; bus1.req_wstrb = 2'b11;
    @(posedge clk); #1 bus1.req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_in_pulse", 32'(we1), 32'd0);
    chk("abort_ready_in_rst", 32'(bus1.req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_we_n", 32'(we1), 32'd1);
    chk("abort_ce_n", 32'(ce1), 32'd1);
    chk("abort_dq_oe", 32'(dqoe1), 32'd0);
    chk("abort_ready", 32'(bus1.req_ready), 32'd1);
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus1.rsp_valid) nr++;
      @(negedge clk);
    end
    chk("abort_no_rsp", 32'(nr), 32'd0);

    // short-timing instance: fill, then random mix
    for (int i = 0; i < 16; i++) begin
      wd = 16'($urandom);
      op2(1'b1, 17'(i), wd, 2'b11, lat, rd);
      ref2[i] = wd;
      chk($sformatf("fill%0d_lat", i), 32'(lat), 32'd3);
    end
    for (int i = 0; i < 200; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 17'($urandom_range(0, 15));
      wd   = 16'($urandom);
      st   = 2'($urandom_range(0, 3));
      op2(wr, addr, wd, st, lat, rd);
      if (wr) begin
        ref2[addr[3:0]] = merge(ref2[addr[3:0]], wd, st);
        chk($sformatf("mix%0d_wr_lat", i), 32'(lat), 32'd3);
      end else begin
        chk($sformatf("mix%0d_rd_lat", i), 32'(lat), 32'd2);
        chk($sformatf("mix%0d_rdata", i), 32'(rd), 32'(ref2[addr[3:0]]));
      end
    end

    repeat (2) @(negedge clk);
    chk("protocol_monitor", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
